mine_placer: RTL and testbench

Upstream stage of the Minesweeper datapath. It randomly places `NUM_MINES` distinct mines on the 5x5 board (cells 0..24) using a free-running LFSR, and delivers the 25-bit mine mask together with a `place_done` level. The datapath latches this mask when play starts. One safe cell, normally the player's first pick, can be excluded from placement.

---
 rtl/mine_pkg.sv | 24 ++
 rtl/mine_placer_lfsr8.sv | 34 +++
 rtl/mine_placer.sv | 107 ++++++++++
 tb/tb_mine_placer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mine_pkg.sv
// rtl/mine_pkg.sv - shared board constants, placer state type and LFSR step helper
package mine_pkg;

  localparam int                NUM_CELLS = 25;
  localparam int                CELL_W    = 5;
  localparam logic [CELL_W-1:0] NO_SAFE   = 5'd31;

  localparam int                LFSR_W    = 8;
  // Taps l[7], l[5], l[4], l[3]: x^8 + x^6 + x^5 + x^4 + 1
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DRAW,
    DONE
  } placer_state_e;

  // One Fibonacci step: shift left, feedback is the parity of the tapped bits
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mine_placer_lfsr8.sv
// rtl/mine_placer_lfsr8.sv - free-running 8-bit Fibonacci LFSR, no enable
module lfsr8
  import mine_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clk_i,
  input  logic              restart_i,
  output logic [LFSR_W-1:0] state_o
);

  // An all-zero state would lock the register, so a zero seed becomes 1
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? 8'h01 : SEED;

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  // Next value is always one step ahead; there is deliberately no hold
  always_comb begin
    state_d = lfsr_step(state_q);
  end

  // Advance on every falling edge, reload the seed on restart
  always_ff @(negedge clk_i) begin
    if (restart_i) begin
      state_q <= SEED_EFF;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/mine_placer.sv
// rtl/mine_placer.sv - random placement of NUM_MINES distinct mines on the 5x5 board
module mine_placer
  import mine_pkg::*;
#(
  parameter int              NUM_MINES = 5,
  parameter logic [LFSR_W-1:0] SEED    = 8'hA5
) (
  input  logic                 clka,
  input  logic                 restart,
  input  logic                 start,
  input  logic [CELL_W-1:0]    safe_cell,
  output logic [NUM_CELLS-1:0] mines,
  output logic [CELL_W-1:0]    mine_count,
  output logic                 busy,
  output logic                 place_done
);

  if (NUM_MINES < 1 || NUM_MINES > NUM_CELLS - 1) begin : g_bad_num_mines
    $error("mine_placer: NUM_MINES must be in 1..24");
  end

  localparam logic [CELL_W-1:0] MINES_TGT = CELL_W'(NUM_MINES);
  localparam logic [CELL_W-1:0] CELLS_LIM = CELL_W'(NUM_CELLS);

  logic [LFSR_W-1:0]    lfsr_w;
  logic [CELL_W-1:0]    cand;
  logic [31:0]          mines_ext;
  logic                 accept;

  placer_state_e        state_q, state_d;
  logic [NUM_CELLS-1:0] mines_q, mines_d;
  logic [CELL_W-1:0]    count_q, count_d;
  logic [CELL_W-1:0]    safe_q, safe_d;
  logic                 busy_q, done_q;

  lfsr8 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk_i     (clka),
    .restart_i (restart),
    .state_o   (lfsr_w)
  );

  // Candidate acceptance plus FSM next-state; safe_q of 25..31 never matches a legal cell
  always_comb begin
    state_d   = state_q;
    mines_d   = mines_q;
    count_d   = count_q;
    safe_d    = safe_q;
    cand      = lfsr_w[CELL_W-1:0];
    mines_ext = {{(32 - NUM_CELLS){1'b0}}, mines_q};
    accept    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = CLEAR;
          mines_d = '0;
          count_d = '0;
          safe_d  = safe_cell;
        end
      end
      CLEAR: begin
        mines_d = '0;
        count_d = '0;
        safe_d  = safe_cell;
        state_d = DRAW;
      end
      DRAW: begin
        accept = (cand < CELLS_LIM) && (cand != safe_q) && !mines_ext[cand];
        if (accept) begin
          mines_d = mines_q | (NUM_CELLS'(1) << cand);
          count_d = count_q + 5'd1;
          if (count_q + 5'd1 == MINES_TGT) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, mask, counter and status flags; restart discards any partial mask
  always_ff @(negedge clka) begin
    if (restart) begin
      state_q <= IDLE;
      mines_q <= '0;
      count_q <= '0;
      safe_q  <= NO_SAFE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mines_q <= mines_d;
      count_q <= count_d;
      safe_q  <= safe_d;
      busy_q  <= (state_d == CLEAR) || (state_d == DRAW);
      done_q  <= (state_d == DONE);
    end
  end

  assign mines      = mines_q;
  assign mine_count = count_q;
  assign busy       = busy_q;
  assign place_done = done_q;

endmodule

// File: tb/tb_mine_placer.sv
// tb/tb_mine_placer.sv - scoreboard bench for mine_placer
module tb_mine_placer;

  logic        clka = 1'b0;
  logic        restart, start, start24;
  logic [4:0]  safe_cell, safe24;
  logic [24:0] mines, mines24;
  logic [4:0]  mine_count, mine_count24;
  logic        busy, busy24, place_done, place_done24;

  always #5 clka = ~clka;

  mine_placer #(.NUM_MINES(5), .SEED(8'hA5)) dut (
    .clka(clka), .restart(restart), .start(start), .safe_cell(safe_cell),
    .mines(mines), .mine_count(mine_count), .busy(busy), .place_done(place_done)
  );

  mine_placer #(.NUM_MINES(24), .SEED(8'h00)) dut24 (
    .clka(clka), .restart(restart), .start(start24), .safe_cell(safe24),
    .mines(mines24), .mine_count(mine_count24), .busy(busy24), .place_done(place_done24)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  typedef struct {
    logic [24:0] mask;
    logic [4:0]  cnt;
    int          done_cyc;
    logic [4:0]  safe;
  } exp_t;

  exp_t sbq[$];

  // Reference LFSR and falling-edge counter
  int         cyc = 0;
  logic [7:0] m_lfsr;
  always @(negedge clka) begin
    cyc <= cyc + 1;
    if (restart) m_lfsr <= 8'hA5;
    else         m_lfsr <= step(m_lfsr);
  end

  // First candidate is two steps after the value seen just before the start edge
  function automatic exp_t predict(input logic [7:0] l0, input logic [4:0] safe, input int base);
    exp_t        e;
    logic [7:0]  s;
    logic [31:0] m;
    int          n;
    int          draws;
    s = step(step(l0));
    m = '0;
    n = 0;
    draws = 0;
    while (n < 5 && draws < 300) begin
      draws++;
      if (s[4:0] < 5'd25 && s[4:0] != safe && m[s[4:0]] == 1'b0) begin
        m[s[4:0]] = 1'b1;
        n++;
      end
      s = step(s);
    end
    e.mask = m[24:0];
    e.cnt = 5'(n);
    e.done_cyc = base + 2 + draws;
    e.safe = safe;
    return e;
  endfunction

  task automatic issue_start(input logic [4:0] s);
    exp_t e;
    @(posedge clka);
    e = predict(m_lfsr, s, cyc);
    sbq.push_back(e);
    safe_cell = s;
    start = 1'b1;
    @(posedge clka);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!place_done && t < 300) begin
      @(posedge clka);
      t++;
    end
    chk("done_within_bound", place_done, 1);
  endtask

  // Monitor: pop and compare on every rising place_done
  logic        prev_done = 1'b0;
  exp_t        mon_e;
  logic [24:0] last_mask = '0;
  always @(posedge clka) begin
    if (place_done && !prev_done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        mon_e = sbq.pop_front();
        last_mask = mon_e.mask;
        chk("mask", mines, mon_e.mask);
        chk("mine_count", mine_count, mon_e.cnt);
        chk("popcount", $countones(mines), mon_e.cnt);
        chk("done_cycle", cyc, mon_e.done_cyc);
        chk("busy_at_done", busy, 0);
        if (mon_e.safe < 5'd25) chk("safe_excluded", mines[mon_e.safe], 0);
      end
    end
    chk("busy_done_exclusive", busy & place_done, 0);
    prev_done <= place_done;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t;
    int   d;
    exp_t e;
    restart = 1'b1;
    start = 1'b0;
    start24 = 1'b0;
    safe_cell = 5'd31;
    safe24 = 5'd31;
    repeat (3) @(posedge clka);

    chk("rst_mines", mines, 0);
    chk("rst_count", mine_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", place_done, 0);
    chk("rst_lfsr", dut.u_lfsr.state_q, 8'hA5);
    chk("rst_lfsr_zero_seed", dut24.u_lfsr.state_q, 8'h01);
    restart = 1'b0;
    @(posedge clka);
    chk("lfsr_step1", dut.u_lfsr.state_q, 8'h4A);
    chk("lfsr_zero_seed_step1", dut24.u_lfsr.state_q, 8'h02);
    @(posedge clka);
    chk("lfsr_step2", dut.u_lfsr.state_q, 8'h95);

    // Basic placement without exclusion, mask stable while done
    issue_start(5'd31);
    wait_done();
    repeat (3) @(posedge clka);
    chk("mask_stable", mines, last_mask);
    chk("done_held", place_done, 1);

    // Re-start from DONE clears immediately
    issue_start(5'd31);
    chk("restart_mines_clear", mines, 0);
    chk("restart_busy", busy, 1);
    chk("restart_done_low", place_done, 0);
    wait_done();

    // Start in the same edge that DRAW completes is ignored
    issue_start(5'd31);
    e = sbq[$];
    d = e.done_cyc;
    t = 0;
    while (cyc < d - 1 && t < 400) begin
      @(posedge clka);
      t++;
    end
    start = 1'b1;
    @(posedge clka);
    start = 1'b0;
    repeat (2) @(posedge clka);
    chk("coincident_start_done", place_done, 1);
    chk("coincident_start_busy", busy, 0);

    // Start during DRAW is dropped; one done only
    issue_start(5'd31);
    repeat (3) @(posedge clka);
    chk("mid_draw_busy", busy, 1);
    start = 1'b1;
    @(posedge clka);
    start = 1'b0;
    wait_done();
    repeat (5) @(posedge clka);
    chk("single_done_hold", place_done, 1);

    // Restart in DRAW at mine_count 2
    issue_start(5'd31);
    t = 0;
    while (mine_count != 5'd2 && t < 300) begin
      @(posedge clka);
      t++;
    end
    chk("reach_count2", mine_count, 2);
    chk("count2_busy", busy, 1);
    restart = 1'b1;
    void'(sbq.pop_back());
    @(posedge clka);
    chk("abort_mines", mines, 0);
    chk("abort_count", mine_count, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", place_done, 0);
    chk("abort_lfsr", dut.u_lfsr.state_q, 8'hA5);
    restart = 1'b0;
    repeat (3) @(posedge clka);
    chk("idle_after_abort", busy | place_done, 0);

    // Safe cell 12, many placements with random start spacing
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 6)) @(posedge clka);
      issue_start(5'd12);
      wait_done();
    end

    // 24 mines, safe cell 0: every other cell filled within 256 edges
    @(posedge clka);
    safe24 = 5'd0;
    start24 = 1'b1;
    @(posedge clka);
    start24 = 1'b0;
    t = 0;
    while (!place_done24 && t < 256) begin
      @(posedge clka);
      t++;
    end
    chk("done24_within_256", place_done24, 1);
    chk("mask24", mines24, 25'h1FFFFFE);
    chk("count24", mine_count24, 24);
    chk("busy24", busy24, 0);

    repeat (2) @(posedge clka);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
